// File: rtl/spi_ojtag_pkg.sv
// Shared types and header layout helpers for the JTAG-DR to SPI flash bridge.
package spi_ojtag_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_e;

  // Header is shifted LSB first: len, then cs_idx, then wpn, then hldn (MSB).
  localparam int unsigned LEN_OFS = 0;

  function automatic int unsigned hdr_width(input int unsigned len_w, input int unsigned cs_w);
    return len_w + cs_w + 2;
  endfunction

  function automatic int unsigned cs_offset(input int unsigned len_w);
    return LEN_OFS + len_w;
  endfunction

  function automatic int unsigned wpn_offset(input int unsigned len_w, input int unsigned cs_w);
    return LEN_OFS + len_w + cs_w;
  endfunction

  function automatic int unsigned hldn_offset(input int unsigned len_w, input int unsigned cs_w);
    return LEN_OFS + len_w + cs_w + 1;
  endfunction

endpackage

// File: rtl/spi_over_jtag_mcs_if.sv
// SPI flash pin bundle: chip selects, gated clock, quad-IO data pins.
interface spi_over_jtag_mcs_if #(
  parameter int unsigned NUM_CS = 2
) ();

  logic [NUM_CS-1:0] csn;
  logic              sck;
  logic              sdi_dq0;
  logic              sdo_dq1;
  logic              wpn_dq2;
  logic              hldn_dq3;

  // Bridge side drives the flash pins and reads MISO.
  modport master (
    output csn, sck, sdi_dq0, wpn_dq2, hldn_dq3,
    input  sdo_dq1
  );

  // Flash side.
  modport slave (
    input  csn, sck, sdi_dq0, wpn_dq2, hldn_dq3,
    output sdo_dq1
  );

endinterface

// File: rtl/spi_ojtag_clkgate.sv
// Latch-based integrated clock gate producing a glitch-free SPI clock.
module spi_ojtag_clkgate (
  input  logic clk_i,
  input  logic en_i,
  output logic gclk_o
);

  logic en_l;

  // Enable is captured only while the clock is low, so it cannot change mid-pulse.
  always_latch begin
    if (!clk_i) en_l <= en_i;
  end

  assign gclk_o = clk_i & en_l;

endmodule

// File: rtl/spi_over_jtag_mcs.sv
// JTAG USER-DR to multi-CS SPI flash bridge: a shifted header selects the flash,
// the WP#/HOLD# levels and the exact payload bit length; CS# is held for exactly
// that many SCK cycles.
module spi_over_jtag_mcs
  import spi_ojtag_pkg::*;
#(
  parameter int unsigned NUM_CS = 2,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned CS_W   = 1
) (
  input  logic jtag_1_TCK,
  input  logic rstn,
  input  logic jtag_1_SEL,
  input  logic jtag_1_CAPTURE,
  input  logic jtag_1_SHIFT,
  input  logic jtag_1_UPDATE,
  input  logic jtag_1_RUNTEST,
  input  logic jtag_1_TDI,
  output logic jtag_1_TDO,
  output logic busy,
  spi_over_jtag_mcs_if.master flash
);

  localparam int unsigned HDR_W    = hdr_width(LEN_W, CS_W);
  localparam int unsigned CS_OFS   = cs_offset(LEN_W);
  localparam int unsigned WPN_OFS  = wpn_offset(LEN_W, CS_W);
  localparam int unsigned HLDN_OFS = hldn_offset(LEN_W, CS_W);
  localparam int unsigned HCNT_W   = $clog2(HDR_W);

  state_e              state_q;
  logic [HDR_W-2:0]    hdr_q;
  logic [HCNT_W-1:0]   hcnt_q;
  logic [LEN_W-1:0]    bcnt_q;
  logic [NUM_CS-1:0]   csn_q;
  logic                wpn_q;
  logic                hldn_q;
  logic                busy_q;

  logic                shift_en;
  logic                abort;
  logic                hdr_last;
  logic                sck_en;
  logic [HDR_W-1:0]    hdr_d;
  logic [LEN_W-1:0]    len_d;
  logic [CS_W-1:0]     cs_d;
  logic [NUM_CS-1:0]   csn_sel_d;

  assign shift_en = jtag_1_SEL & jtag_1_SHIFT;
  assign abort    = (jtag_1_SEL & jtag_1_UPDATE) | jtag_1_RUNTEST;
  assign hdr_last = (hcnt_q == HCNT_W'(HDR_W - 1));

  // The register holds HDR_W-1 bits; the final header bit is taken straight
  // from TDI so all fields can be latched on the same edge it arrives.
  assign hdr_d = {jtag_1_TDI, hdr_q};
  assign len_d = hdr_d[LEN_OFS +: LEN_W];
  assign cs_d  = hdr_d[CS_OFS +: CS_W];

  // Decode the header index to an active-low select; out-of-range selects none.
  always_comb begin
    csn_sel_d = '1;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (32'(cs_d) == i) csn_sel_d[i] = 1'b0;
    end
  end

  // Bridge FSM with registered chip selects, pin levels and busy.
  always_ff @(posedge jtag_1_TCK) begin
    if (!rstn) begin
      state_q <= IDLE;
      hdr_q   <= '0;
      hcnt_q  <= '0;
      bcnt_q  <= '0;
      csn_q   <= '1;
      wpn_q   <= 1'b1;
      hldn_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else if (abort) begin
      state_q <= IDLE;
      csn_q   <= '1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (jtag_1_SEL && jtag_1_CAPTURE) begin
            state_q <= HDR;
            hcnt_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        HDR: begin
          if (shift_en) begin
            hdr_q <= hdr_d[HDR_W-1:1];
            if (hdr_last) begin
              wpn_q  <= hdr_d[WPN_OFS];
              hldn_q <= hdr_d[HLDN_OFS];
              bcnt_q <= len_d;
              if (len_d == '0) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= XFER;
                csn_q   <= csn_sel_d;
              end
            end else begin
              hcnt_q <= hcnt_q + 1'b1;
            end
          end
        end
        XFER: begin
          if (shift_en) begin
            bcnt_q <= bcnt_q - LEN_W'(1);
            if (bcnt_q == LEN_W'(1)) begin
              state_q <= DONE;
              csn_q   <= '1;
              busy_q  <= 1'b0;
            end
          end
        end
        DONE: begin
          // Wait for Update-DR; extra shift bits are ignored.
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // rstn is folded into the enable so SCK stops at once on a mid-transfer reset.
  assign sck_en = (state_q == XFER) & jtag_1_SEL & jtag_1_SHIFT & rstn;

  spi_ojtag_clkgate u_clkgate (
    .clk_i  (jtag_1_TCK),
    .en_i   (sck_en),
    .gclk_o (flash.sck)
  );

  assign flash.csn      = csn_q;
  assign flash.wpn_dq2  = wpn_q;
  assign flash.hldn_dq3 = hldn_q;
  assign flash.sdi_dq0  = (state_q == XFER) & jtag_1_TDI;
  assign jtag_1_TDO     = (state_q == XFER) ? flash.sdo_dq1 : jtag_1_TDI;
  assign busy           = busy_q;

endmodule

// File: tb/tb_spi_over_jtag_mcs.sv
// Bench for the JTAG-DR to SPI flash bridge: count-based reference model plus
// directed transactions with hand-computed expectations.
module tb_spi_over_jtag_mcs;

  localparam int unsigned NUM_CS = 2;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned CS_W   = 2;
  localparam int unsigned HDR_W  = LEN_W + CS_W + 2;

  logic clk = 1'b0;
  logic rstn, jsel, jcap, jshift, jupd, jrt, tdi;
  logic tdo, busy;
  logic sdo = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;
  int sck_cnt  = 0;

  always #5 clk = ~clk;

  spi_over_jtag_mcs_if #(.NUM_CS(NUM_CS)) fif ();

  assign fif.sdo_dq1 = sdo;

  spi_over_jtag_mcs #(
    .NUM_CS (NUM_CS),
    .LEN_W  (LEN_W),
    .CS_W   (CS_W)
  ) dut (
    .jtag_1_TCK     (clk),
    .rstn           (rstn),
    .jtag_1_SEL     (jsel),
    .jtag_1_CAPTURE (jcap),
    .jtag_1_SHIFT   (jshift),
    .jtag_1_UPDATE  (jupd),
    .jtag_1_RUNTEST (jrt),
    .jtag_1_TDI     (tdi),
    .jtag_1_TDO     (tdo),
    .busy           (busy),
    .flash          (fif)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge fif.sck) sck_cnt++;

  // Flash stand-in on CS1: answers command 0x9F with 24'hEF4018, shifting out on SCK fall.
  logic [23:0] resp = 24'hEF4018;
  logic [7:0]  fl_cmd = 8'h00;
  int          fl_r = 0;
  always @(posedge fif.sck or negedge fif.sck or posedge fif.csn[1]) begin
    if (fif.csn[1]) begin
      fl_r = 0;
      sdo  = 1'b0;
    end else if (fif.sck) begin
      fl_r++;
      if (fl_r <= 8) fl_cmd = {fl_cmd[6:0], fif.sdi_dq0};
    end else begin
      if (fl_r >= 8 && fl_r < 32 && fl_cmd == 8'h9F) sdo = resp[31 - fl_r];
      else sdo = 1'b0;
    end
  end

  // Reference model: tracks header and payload bit counts per DR scan.
  logic             mvalid = 1'b0;
  logic             active = 1'b0;
  logic             in_hdr = 1'b0;
  logic             in_xfer = 1'b0;
  logic             m_sck = 1'b0;
  logic [HDR_W-1:0] hb = '0;
  int               nh = 0, nx = 0, mlen = 0, mcs = 0;
  logic             mwp = 1'b1, mhd = 1'b1;

  always @(posedge clk) begin
    m_sck = in_xfer && jsel && jshift && rstn;
    if (!rstn) begin
      mvalid = 1'b1; active = 1'b0; nh = 0; nx = 0; mlen = 0; mcs = 0;
      mwp = 1'b1; mhd = 1'b1;
    end else if ((jsel && jupd) || jrt) begin
      active = 1'b0;
    end else if (!active) begin
      if (jsel && jcap) begin
        active = 1'b1; nh = 0; nx = 0;
      end
    end else if (jsel && jshift) begin
      if (nh < HDR_W) begin
        hb[nh] = tdi;
        nh++;
        if (nh == HDR_W) begin
          mlen = int'(hb[15:0]);
          mcs  = int'(hb[17:16]);
          mwp  = hb[18];
          mhd  = hb[19];
        end
      end else if (nx < mlen) begin
        nx++;
      end
    end
    in_hdr  = active && (nh < HDR_W);
    in_xfer = active && (nh == HDR_W) && (nx < mlen);
  end

  // Per-cycle comparison of all outputs against the model.
  always begin
    logic [1:0] exp_csn;
    @(posedge clk);
    #2;
    if (mvalid) begin
      exp_csn = (in_xfer && mcs < int'(NUM_CS)) ? ~(2'b01 << mcs) : 2'b11;
      chk("csn", 32'(fif.csn), 32'(exp_csn));
      chk("busy", 32'(busy), 32'(in_hdr || in_xfer));
      chk("wpn", 32'(fif.wpn_dq2), 32'(mwp));
      chk("hldn", 32'(fif.hldn_dq3), 32'(mhd));
      chk("sck_high", 32'(fif.sck), 32'(m_sck));
      chk("sdi", 32'(fif.sdi_dq0), 32'(in_xfer ? tdi : 1'b0));
      chk("tdo", 32'(tdo), 32'(in_xfer ? sdo : tdi));
    end
    @(negedge clk);
    #1;
    if (mvalid) chk("sck_low", 32'(fif.sck), 32'd0);
  end

  logic sdi_q[$];
  logic tdo_q[$];

  // One TCK cycle: inputs applied at negedge, host-side samples taken before the rising edge.
  task automatic cyc(input logic s, input logic c, input logic sh, input logic u, input logic r, input logic d);
    logic sdi_pre, tdo_pre;
    jsel = s; jcap = c; jshift = sh; jupd = u; jrt = r; tdi = d;
    #1;
    sdi_pre = fif.sdi_dq0;
    tdo_pre = tdo;
    @(posedge clk);
    #2;
    if (fif.sck) begin
      sdi_q.push_back(sdi_pre);
      tdo_q.push_back(tdo_pre);
    end
    @(negedge clk);
  endtask

  task automatic shift(input logic d);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, d);
  endtask

  task automatic send_hdr(input int len, input int cs, input logic wp, input logic hd);
    logic [HDR_W-1:0] h;
    h = {hd, wp, 2'(cs), 16'(len)};
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < int'(HDR_W); i++) shift(h[i]);
  endtask

  task automatic update_dr();
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int          base, bc;
    logic [7:0]  b, v;
    logic [23:0] r;

    rstn = 1'b0; jsel = 1'b0; jcap = 1'b0; jshift = 1'b0; jupd = 1'b0; jrt = 1'b0; tdi = 1'b0;
    @(negedge clk);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_csn", 32'(fif.csn), 32'h3);
    chk("rst_wpn", 32'(fif.wpn_dq2), 32'd1);
    chk("rst_hldn", 32'(fif.hldn_dq3), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sck", 32'(fif.sck), 32'd0);
    rstn = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // len=8 to CS1, WP#=0, HOLD#=1, payload 0x9F LSB first.
    base = sck_cnt; sdi_q.delete();
    send_hdr(8, 1, 1'b0, 1'b1);
    b = 8'h9F;
    for (int i = 0; i < 8; i++) begin
      shift(b[i]);
      if (i == 3) chk("t2_csn_mid", 32'(fif.csn), 32'h1);
    end
    chk("t2_csn_end", 32'(fif.csn), 32'h3);
    chk("t2_busy_end", 32'(busy), 32'd0);
    chk("t2_wpn", 32'(fif.wpn_dq2), 32'd0);
    chk("t2_hldn", 32'(fif.hldn_dq3), 32'd1);
    shift(1'b1);
    shift(1'b0);
    chk("t2_sck_cnt", 32'(sck_cnt - base), 32'd8);
    v = '0;
    for (int i = 0; i < 8; i++) v[i] = sdi_q[i];
    chk("t2_sdi_byte", 32'(v), 32'h9F);
    update_dr();

    // len=40 to CS1: 0x9F sent MSB first on the wire, then 32 dummy bits.
    base = sck_cnt; tdo_q.delete();
    send_hdr(40, 1, 1'b1, 1'b1);
    for (int i = 7; i >= 0; i--) shift(b[i]);
    for (int i = 0; i < 32; i++) shift(1'b0);
    chk("t3_sck_cnt", 32'(sck_cnt - base), 32'd40);
    r = '0;
    for (int i = 8; i < 32; i++) r = {r[22:0], tdo_q[i]};
    chk("t3_jedec_id", 32'(r), 32'hEF4018);
    update_dr();

    // len=16 to CS0 with a 5-cycle Pause-DR after bit 6.
    base = sck_cnt;
    send_hdr(16, 0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) shift(1'(i));
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4_pause_csn", 32'(fif.csn), 32'h2);
    chk("t4_pause_sck", 32'(sck_cnt - base), 32'd6);
    for (int i = 0; i < 10; i++) shift(1'(i + 1));
    chk("t4_sck_cnt", 32'(sck_cnt - base), 32'd16);
    chk("t4_csn_end", 32'(fif.csn), 32'h3);
    update_dr();

    // len=16 to CS1, Update-DR after bit 10 aborts; pin levels stay latched.
    base = sck_cnt;
    send_hdr(16, 1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) shift(1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5_csn", 32'(fif.csn), 32'h3);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_wpn_kept", 32'(fif.wpn_dq2), 32'd0);
    chk("t5_hldn_kept", 32'(fif.hldn_dq3), 32'd0);
    for (int i = 0; i < 5; i++) shift(1'b1);
    chk("t5_sck_cnt", 32'(sck_cnt - base), 32'd10);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // cs_idx=3 is out of range: timed normally, no chip select.
    base = sck_cnt; bc = 0;
    send_hdr(8, 3, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (busy) bc++;
      shift(1'b1);
      if (i == 3) chk("t6_csn_mid", 32'(fif.csn), 32'h3);
    end
    chk("t6_busy_cycles", 32'(bc), 32'd8);
    chk("t6_sck_cnt", 32'(sck_cnt - base), 32'd8);
    chk("t6_done_busy", 32'(busy), 32'd0);
    update_dr();

    // len=0 goes straight to DONE with no SCK.
    base = sck_cnt;
    send_hdr(0, 0, 1'b1, 1'b1);
    chk("t7_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) shift(1'b1);
    chk("t7_sck_cnt", 32'(sck_cnt - base), 32'd0);
    update_dr();

    // Run-Test/Idle during the header wins over the shift in the same cycle.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) shift(1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("t8_abort_busy", 32'(busy), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a transfer to CS0.
    base = sck_cnt;
    send_hdr(16, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) shift(1'b1);
    rstn = 1'b0;
    shift(1'b1);
    chk("t9_csn", 32'(fif.csn), 32'h3);
    chk("t9_wpn", 32'(fif.wpn_dq2), 32'd1);
    chk("t9_hldn", 32'(fif.hldn_dq3), 32'd1);
    chk("t9_busy", 32'(busy), 32'd0);
    chk("t9_sck_cnt", 32'(sck_cnt - base), 32'd4);
    rstn = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
